// File: rtl/regfile_ctx_if.sv
// regfile_ctx_if: register-file port plus save/restore word streams
interface regfile_ctx_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic              reg_read;
  logic [ADDR_W-1:0] read_reg1;
  logic [ADDR_W-1:0] read_reg2;
  logic [DATA_W-1:0] read_data1;
  logic [DATA_W-1:0] read_data2;
  logic              reg_write;
  logic [ADDR_W-1:0] write_reg;
  logic [DATA_W-1:0] write_data;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  modport master (
    output reg_read, read_reg1, read_reg2, reg_write, write_reg, write_data,
           out_valid, out_data, in_ready,
    input  read_data1, read_data2, out_ready, in_valid, in_data
  );
  modport slave (
    input  reg_read, read_reg1, read_reg2, reg_write, write_reg, write_data,
           out_valid, out_data, in_ready,
    output read_data1, read_data2, out_ready, in_valid, in_data
  );
endinterface

// File: rtl/regfile_ctx_engine.sv
// regfile_ctx_engine: saves/restores the whole register bank over valid/ready word streams
module regfile_ctx_engine #(
  parameter int NUM_REGS = 32,
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          mode,
  input  logic          abort,
  output logic          busy,
  output logic          done,
  regfile_ctx_if.master rf
);
  typedef enum logic [2:0] {IDLE, SAVE_RD, SAVE_OUT, RESTORE, DONE} state_t;
  localparam logic [ADDR_W:0] LAST_PAIR = (ADDR_W+1)'(NUM_REGS - 2);
  localparam logic [ADDR_W:0] LAST_REG  = (ADDR_W+1)'(NUM_REGS - 1);
  state_t            state, state_nx;
  logic [ADDR_W:0]   ptr, ptr_nx, ptr_inc1, ptr_inc2;
  logic [DATA_W-1:0] buf0, buf1;
  logic              sel, sel_nx;
  logic              out_hs, in_hs;
  assign ptr_inc1 = ptr + 1'b1;
  assign ptr_inc2 = ptr + 2'd2;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      ptr   <= '0;
      sel   <= 1'b0;
      buf0  <= '0;
      buf1  <= '0;
    end else begin
      state <= state_nx;
      ptr   <= ptr_nx;
      sel   <= sel_nx;
      if (state == SAVE_RD && !abort) begin
        buf0 <= rf.read_data1;
        buf1 <= rf.read_data2;
      end
    end
  // abort masks every strobe so the cycle it lands in carries no handshake or write
  always_comb begin
    state_nx      = state;
    ptr_nx        = ptr;
    sel_nx        = sel;
    busy          = state != IDLE;
    done          = state == DONE && !abort;
    rf.reg_read   = state == SAVE_RD && !abort;
    rf.read_reg1  = state == SAVE_RD ? ptr[ADDR_W-1:0] : '0;
    rf.read_reg2  = state == SAVE_RD ? ptr_inc1[ADDR_W-1:0] : '0;
    rf.out_valid  = state == SAVE_OUT && !abort;
    rf.out_data   = state == SAVE_OUT ? (sel ? buf1 : buf0) : '0;
    rf.in_ready   = state == RESTORE && !abort;
    in_hs         = state == RESTORE && !abort && rf.in_valid;
    out_hs        = state == SAVE_OUT && !abort && rf.out_ready;
    rf.reg_write  = in_hs;
    rf.write_reg  = state == RESTORE ? ptr[ADDR_W-1:0] : '0;
    rf.write_data = state == RESTORE ? rf.in_data : '0;
    if (abort && busy)
      state_nx = IDLE;
    else
      case (state)
        IDLE: if (start) begin
          state_nx = mode ? RESTORE : SAVE_RD;
          ptr_nx   = '0;
        end
        SAVE_RD: begin
          state_nx = SAVE_OUT;
          sel_nx   = 1'b0;
        end
        SAVE_OUT: if (out_hs) begin
          sel_nx = 1'b1;
          if (sel) begin
            ptr_nx   = ptr_inc2;
            state_nx = ptr == LAST_PAIR ? DONE : SAVE_RD;
          end
        end
        RESTORE: if (in_hs) begin
          ptr_nx   = ptr_inc1;
          state_nx = ptr == LAST_REG ? DONE : RESTORE;
        end
        default: state_nx = IDLE;
      endcase
  end
endmodule
